// File: rtl/debug_ram_sequencer.sv
// Load/run/dump controller for the RV32Core debug RAM ports: host words go into DataRAM then InstRAM, the core runs for a fixed budget, then DataRAM is streamed out.
// Latency: writes land the same cycle as a load handshake; each dumped word costs RD+CAP+OUT (>=3 cycles).
// Backpressure: load_ready is high only in the load states; dump_data is held in OUT until dump_ready.
module debug_ram_sequencer #(
    parameter int WORDS      = 4096,
    parameter int RST_CYCLES = 8,
    parameter int RUN_CYCLES = 200000
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST_N,
    input  logic        start,
    input  logic        abort,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        dump_valid,
    output logic [31:0] dump_data,
    input  logic        dump_ready,
    output logic [31:0] Debug_DataRAM_A2,
    output logic [31:0] Debug_DataRAM_WD2,
    output logic [3:0]  Debug_DataRAM_WE2,
    input  logic [31:0] Debug_DataRAM_RD2,
    output logic [31:0] Debug_InstRAM_A2,
    output logic [31:0] Debug_InstRAM_WD2,
    output logic [3:0]  Debug_InstRAM_WE2,
    output logic        core_rst,
    output logic        busy,
    output logic        done
);

    localparam int IW        = $clog2(WORDS);
    localparam int HW        = ($clog2(RST_CYCLES + 1) > 0) ? $clog2(RST_CYCLES + 1) : 1;
    localparam int RW        = ($clog2(RUN_CYCLES + 1) > 0) ? $clog2(RUN_CYCLES + 1) : 1;
    localparam int HOLD_LAST = (RST_CYCLES > 0) ? RST_CYCLES - 1 : 0;
    localparam int RUN_LAST  = (RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0;
    localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_D, LOAD_I, HOLD, RUN, RD, CAP, OUT, DONE
    } seqState_t;

    seqState_t      state, stateNext;
    logic [IW-1:0]  idx, idxNext;
    logic [HW-1:0]  holdCnt;
    logic [RW-1:0]  runCnt;
    logic [31:0]    wordAddr;
    logic           lastWord, holdDone, runDone;

    assign wordAddr = {{(30 - IW){1'b0}}, idx, 2'b00};
    assign lastWord = (idx == IDX_LAST);
    assign holdDone = (holdCnt == HW'(HOLD_LAST));
    assign runDone  = (RUN_CYCLES == 0) || (runCnt == RW'(RUN_LAST));

    always_comb begin
        stateNext         = state;
        idxNext           = idx;
        load_ready        = 1'b0;
        dump_valid        = 1'b0;
        busy              = 1'b1;
        done              = 1'b0;
        Debug_DataRAM_A2  = 32'd0;
        Debug_DataRAM_WD2 = 32'd0;
        Debug_DataRAM_WE2 = 4'd0;
        Debug_InstRAM_A2  = 32'd0;
        Debug_InstRAM_WD2 = 32'd0;
        Debug_InstRAM_WE2 = 4'd0;

        case (state)
            IDLE, DONE: begin
                busy = 1'b0;
                done = (state == DONE);
                if (start) begin
                    stateNext = LOAD_D;
                    idxNext   = '0;
                end
            end
            LOAD_D: begin
                // abort wins over a same-cycle word: it is neither accepted nor written
                load_ready       = !abort;
                Debug_DataRAM_A2 = wordAddr;
                if (load_valid && !abort) begin
                    Debug_DataRAM_WD2 = load_data;
                    Debug_DataRAM_WE2 = 4'b1111;
                    idxNext           = idx + IW'(1);
                    if (lastWord) begin
                        stateNext = LOAD_I;
                        idxNext   = '0;
                    end
                end
            end
            LOAD_I: begin
                load_ready       = !abort;
                Debug_InstRAM_A2 = wordAddr;
                if (load_valid && !abort) begin
                    Debug_InstRAM_WD2 = load_data;
                    Debug_InstRAM_WE2 = 4'b1111;
                    idxNext           = idx + IW'(1);
                    if (lastWord) begin
                        stateNext = HOLD;
                    end
                end
            end
            HOLD: begin
                if (holdDone) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (runDone) begin
                    stateNext = RD;
                    idxNext   = '0;
                end
            end
            RD: begin
                Debug_DataRAM_A2 = wordAddr;
                stateNext        = CAP;
            end
            CAP: begin
                // address held so the synchronous read port keeps returning the same word
                Debug_DataRAM_A2 = wordAddr;
                stateNext        = OUT;
            end
            OUT: begin
                dump_valid = !abort;
                if (dump_ready && !abort) begin
                    if (lastWord) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = RD;
                        idxNext   = idx + IW'(1);
                    end
                end
            end
            default: begin
                busy      = 1'b0;
                stateNext = IDLE;
            end
        endcase

        if (abort) begin
            stateNext = IDLE;
            idxNext   = idx;
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state     <= IDLE;
            idx       <= '0;
            holdCnt   <= '0;
            runCnt    <= '0;
            dump_data <= 32'd0;
            core_rst  <= 1'b1;
        end else begin
            state   <= stateNext;
            idx     <= idxNext;
            holdCnt <= (state == HOLD && stateNext == HOLD) ? holdCnt + HW'(1) : '0;
            runCnt  <= (state == RUN && stateNext == RUN) ? runCnt + RW'(1) : '0;
            if (state == CAP) begin
                dump_data <= Debug_DataRAM_RD2;
            end
            // registered from next state so the core reset is glitch-free yet aligned with RUN
            core_rst <= !(stateNext == RUN && RUN_CYCLES != 0);
        end
    end

endmodule

// File: tb/tb_debug_ram_sequencer.sv
// Bench for debug_ram_sequencer: phase-level reference model compared every cycle, plus literal checks on RAM images, run timing and dump order.
module tb_debug_ram_sequencer;

    localparam int WORDS = 4;
    localparam int RSTC  = 8;
    localparam int RUNC  = 20;
    localparam int AW    = $clog2(WORDS);

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST_N = 1'b1;
    logic        start = 1'b0, abort = 1'b0, load_valid = 1'b0, dump_ready = 1'b0;
    logic [31:0] load_data = 32'd0;
    logic        load_ready, dump_valid, core_rst, busy, done;
    logic [31:0] dump_data;
    logic [31:0] Debug_DataRAM_A2, Debug_DataRAM_WD2, Debug_DataRAM_RD2;
    logic [31:0] Debug_InstRAM_A2, Debug_InstRAM_WD2;
    logic [3:0]  Debug_DataRAM_WE2, Debug_InstRAM_WE2;

    int checks = 0;
    int failures = 0;

    always #5 CPU_CLK = ~CPU_CLK;

    debug_ram_sequencer #(.WORDS(WORDS), .RST_CYCLES(RSTC), .RUN_CYCLES(RUNC)) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N), .start(start), .abort(abort),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
        .Debug_DataRAM_A2(Debug_DataRAM_A2), .Debug_DataRAM_WD2(Debug_DataRAM_WD2),
        .Debug_DataRAM_WE2(Debug_DataRAM_WE2), .Debug_DataRAM_RD2(Debug_DataRAM_RD2),
        .Debug_InstRAM_A2(Debug_InstRAM_A2), .Debug_InstRAM_WD2(Debug_InstRAM_WD2),
        .Debug_InstRAM_WE2(Debug_InstRAM_WE2), .core_rst(core_rst), .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // RAMs behind the debug ports: byte-enable writes, 1-cycle synchronous read
    logic [31:0] dataRam [WORDS];
    logic [31:0] instRam [WORDS];
    logic [31:0] rd2 = 32'd0;
    int writeCount = 0;
    assign Debug_DataRAM_RD2 = rd2;

    always @(posedge CPU_CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (Debug_DataRAM_WE2[b]) dataRam[Debug_DataRAM_A2[AW+1:2]][8*b +: 8] <= Debug_DataRAM_WD2[8*b +: 8];
            if (Debug_InstRAM_WE2[b]) instRam[Debug_InstRAM_A2[AW+1:2]][8*b +: 8] <= Debug_InstRAM_WD2[8*b +: 8];
        end
        if (Debug_DataRAM_WE2 != 4'd0) writeCount++;
        if (Debug_InstRAM_WE2 != 4'd0) writeCount++;
        rd2 <= dataRam[Debug_DataRAM_A2[AW+1:2]];
    end

    // Reference model: phase plus word/cycle counters, stepped from the inputs only
    typedef enum {P_IDLE, P_LOADD, P_LOADI, P_HOLD, P_RUN, P_FETCH, P_OUT, P_DONE} phase_t;
    phase_t      ph = P_IDLE;
    int          wIdx = 0, cnt = 0, fetchLeft = 0;
    logic [31:0] expData [WORDS];

    always @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            ph = P_IDLE; wIdx = 0; cnt = 0;
        end else if (abort) begin
            ph = P_IDLE;
        end else begin
            case (ph)
                P_IDLE, P_DONE: if (start) begin ph = P_LOADD; wIdx = 0; end
                P_LOADD: if (load_valid) begin
                    expData[wIdx] = load_data;
                    if (wIdx == WORDS - 1) begin ph = P_LOADI; wIdx = 0; end
                    else wIdx++;
                end
                P_LOADI: if (load_valid) begin
                    if (wIdx == WORDS - 1) begin ph = P_HOLD; cnt = 0; end
                    else wIdx++;
                end
                P_HOLD: begin
                    cnt++;
                    if (cnt == RSTC) begin ph = P_RUN; cnt = 0; end
                end
                P_RUN: begin
                    cnt++;
                    if (RUNC == 0 || cnt == RUNC) begin ph = P_FETCH; fetchLeft = 1; wIdx = 0; end
                end
                P_FETCH: if (fetchLeft == 0) ph = P_OUT; else fetchLeft--;
                P_OUT: if (dump_ready) begin
                    if (wIdx == WORDS - 1) ph = P_DONE;
                    else begin wIdx++; ph = P_FETCH; fetchLeft = 1; end
                end
                default: ph = P_IDLE;
            endcase
        end
    end

    // Per-cycle compare plus timing/dump monitors
    bit          chkOn = 1'b0;
    int          cyc = 0, lastLoadCyc = 0, runStartCyc = 0, lowCnt = 0;
    logic        prevRst = 1'b1;
    logic [31:0] dumpQ [$];
    logic        expLoad, expDWe, expIWe;
    logic [4:0]  expCtl;

    always @(posedge CPU_CLK) cyc++;

    always @(negedge CPU_CLK) begin
        if (chkOn) begin
            expLoad = (ph == P_LOADD || ph == P_LOADI) && !abort;
            expCtl  = {expLoad, (ph != P_IDLE && ph != P_DONE), (ph == P_DONE),
                       !(ph == P_RUN && RUNC > 0), (ph == P_OUT && !abort)};
            check("ctl{lr,busy,done,rst,dv}", 32'({load_ready, busy, done, core_rst, dump_valid}), 32'(expCtl));
            expDWe = (ph == P_LOADD) && expLoad && load_valid;
            expIWe = (ph == P_LOADI) && expLoad && load_valid;
            check("dram_we", 32'(Debug_DataRAM_WE2), expDWe ? 32'hF : 32'h0);
            check("iram_we", 32'(Debug_InstRAM_WE2), expIWe ? 32'hF : 32'h0);
            if (expDWe) begin
                check("dram_addr", Debug_DataRAM_A2, 32'(wIdx * 4));
                check("dram_wd", Debug_DataRAM_WD2, load_data);
            end
            if (expIWe) begin
                check("iram_addr", Debug_InstRAM_A2, 32'(wIdx * 4));
                check("iram_wd", Debug_InstRAM_WD2, load_data);
            end
            if (ph == P_FETCH) check("rd_addr", Debug_DataRAM_A2, 32'(wIdx * 4));
            if (ph == P_OUT && !abort) check("dump_data", dump_data, expData[wIdx]);
        end
        if (dump_valid && dump_ready && !abort) dumpQ.push_back(dump_data);
        if (Debug_InstRAM_WE2 != 4'd0) lastLoadCyc = cyc;
        if (!core_rst) lowCnt++;
        if (!core_rst && prevRst) runStartCyc = cyc;
        prevRst = core_rst;
    end

    task automatic step();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic doStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Streams WORDS data words then WORDS inst words; toggle inserts an idle cycle between words
    task automatic loadImages(input logic [31:0] dBase, input logic [31:0] iBase, input bit toggle);
        for (int i = 0; i < 2 * WORDS; i++) begin
            load_valid = 1'b1;
            load_data  = (i < WORDS) ? dBase + 32'(i) : iBase + 32'(i - WORDS);
            step();
            if (toggle) begin
                load_valid = 1'b0;
                step();
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic waitDumpValid();
        int k = 0;
        while (!dump_valid && k < 200) begin
            step();
            k++;
        end
        check("wait_dump_valid", 32'(dump_valid), 32'd1);
    endtask

    task automatic dumpAll(input int delay);
        for (int w = 0; w < WORDS; w++) begin
            waitDumpValid();
            repeat (delay) step();
            dump_ready = 1'b1;
            step();
            dump_ready = 1'b0;
        end
    endtask

    task automatic checkDump(input string name, input logic [31:0] base);
        check({name, "_count"}, 32'(dumpQ.size()), 32'(WORDS));
        for (int i = 0; i < WORDS && i < dumpQ.size(); i++) check(name, dumpQ[i], base + 32'(i));
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            dataRam[i] = 32'hEE00_0000 + 32'(i);
            instRam[i] = 32'hDD00_0000 + 32'(i);
            expData[i] = 32'hEE00_0000 + 32'(i);
        end
        #1 CPU_RST_N = 1'b0;
        #2;
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_dump_valid", 32'(dump_valid), 32'd0);
        check("rst_dump_data", dump_data, 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("rst_we", 32'({Debug_DataRAM_WE2, Debug_InstRAM_WE2}), 32'd0);
        check("rst_addr", Debug_DataRAM_A2 | Debug_InstRAM_A2, 32'd0);
        chkOn = 1'b1;
        repeat (2) step();
        CPU_RST_N = 1'b1;
        step();

        // 1: continuous stream 1..8, start held during load must be ignored
        lowCnt = 0; dumpQ.delete(); writeCount = 0;
        doStart();
        start = 1'b1;
        loadImages(32'd1, 32'd5, 1'b0);
        start = 1'b0;
        check("t1_writes", 32'(writeCount), 32'd8);
        for (int i = 0; i < WORDS; i++) begin
            check("t1_dataram", dataRam[i], 32'(i + 1));
            check("t1_instram", instRam[i], 32'(i + 5));
        end
        dumpAll(0);
        check("t1_done", 32'({done, busy}), 32'b10);
        checkDump("t1_dump", 32'd1);
        check("t1_run_low_cycles", 32'(lowCnt), 32'(RUNC));
        check("t1_hold_gap", 32'(runStartCyc - lastLoadCyc), 32'(RSTC + 1));

        // 2: restart from DONE, toggling valid, dump with ready held off 5 cycles per word
        lowCnt = 0; dumpQ.delete(); writeCount = 0;
        doStart();
        loadImages(32'hA0A0_0000, 32'h0000_1000, 1'b1);
        check("t2_writes", 32'(writeCount), 32'd8);
        dumpAll(5);
        check("t2_done", 32'(done), 32'd1);
        checkDump("t2_dump", 32'hA0A0_0000);
        check("t2_run_low_cycles", 32'(lowCnt), 32'(RUNC));

        // 3: abort mid LOAD_I with a word offered the same cycle
        doStart();
        for (int i = 0; i < WORDS + 2; i++) begin
            load_valid = 1'b1;
            load_data  = (i < WORDS) ? 32'h3000 + 32'(i) : 32'h3100 + 32'(i - WORDS);
            step();
        end
        load_data = 32'h3199;
        abort = 1'b1;
        @(negedge CPU_CLK);
        check("t3_abort_ready", 32'({load_ready, Debug_InstRAM_WE2}), 32'd0);
        step();
        abort = 1'b0; load_valid = 1'b0;
        check("t3_idle", 32'({busy, done, core_rst, load_ready, dump_valid}), 32'b00100);
        step();
        check("t3_inst0", instRam[0], 32'h3100);
        check("t3_inst1", instRam[1], 32'h3101);
        check("t3_inst2_kept", instRam[2], 32'h1002);

        // 4: abort mid OUT with dump_ready high the same cycle
        dumpQ.delete();
        doStart();
        loadImages(32'h5000, 32'h6000, 1'b0);
        waitDumpValid();
        dump_ready = 1'b1;
        step();
        dump_ready = 1'b0;
        waitDumpValid();
        abort = 1'b1; dump_ready = 1'b1;
        @(negedge CPU_CLK);
        check("t4_abort_dv", 32'(dump_valid), 32'd0);
        step();
        abort = 1'b0; dump_ready = 1'b0;
        check("t4_idle", 32'({busy, done, core_rst, load_ready, dump_valid}), 32'b00100);
        check("t4_dumped", 32'(dumpQ.size()), 32'd1);

        // 5: reset pulse while the core runs, then a clean full sequence
        doStart();
        loadImages(32'h7000, 32'h8000, 1'b0);
        for (int k = 0; k < 50 && core_rst; k++) step();
        check("t5_core_running", 32'(core_rst), 32'd0);
        repeat (3) step();
        #2 CPU_RST_N = 1'b0;
        #1;
        check("t5_async_idle", 32'({busy, core_rst, load_ready, dump_valid}), 32'b0100);
        step();
        CPU_RST_N = 1'b1;
        step();
        lowCnt = 0; dumpQ.delete();
        doStart();
        loadImages(32'h9000, 32'h9100, 1'b0);
        dumpAll(1);
        check("t5_done", 32'(done), 32'd1);
        checkDump("t5_dump", 32'h9000);
        check("t5_run_low_cycles", 32'(lowCnt), 32'(RUNC));

        chkOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
